regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the 32x32 register file between two writeback sources. Source A is the in-order pipeline writeback. Source B is the multi-cycle unit path (mul/div, late loads), which goes through a small FIFO. The block registers the winning write one cycle ahead of the regfile's negedge write, and exports a pending-write mask for the decode-stage hazard logic.

## Interface
- `DEPTH`, 2, number of entries in the B FIFO (≥2, power of two)
- `DATA_W`, 32, write data width

- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  pipeline writeback request
- `a_ready`  out  1  A accepted this cycle when `a_valid && a_ready`
- `a_num`  in  5  A destination register
- `a_data`  in  DATA_W  A write data
- `b_valid`  in  1  multi-cycle unit result request
- `b_ready`  out  1  B accepted (pushed) when `b_valid && b_ready`
- `b_num`  in  5  B destination register
- `b_data`  in  DATA_W  B write data
- `wr_en`  out  1  regfile write enable (registered)
- `wr_num`  out  5  regfile write address (registered)
- `wr_data`  out  DATA_W  regfile write data (registered)
- `pending`  out  32  bit i set while a write to ri is queued or in the output stage
- `b_count`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- One write slot per cycle. Slot selection, evaluated combinationally each cycle:
  - FIFO full (`b_count == DEPTH`): FIFO head wins.
  - Otherwise, if A handshakes: A wins.
  - Otherwise, if FIFO is non-empty: FIFO head wins.
  - Otherwise: no write.
- `b_ready = (b_count != DEPTH)`. No pass-through at full. B always enters the FIFO and is never written in its acceptance cycle.
- `a_ready = !full && !(a_num != 0 && fifo_hit[a_num])`, where `fifo_hit` marks destinations held by any FIFO entry.
  - This preserves WAW order: A cannot overtake an older B write to the same register.
  - `a_ready` does not depend on `a_valid`.
- Push and pop in the same cycle are allowed. Occupancy is unchanged in that case.
- Writes to r0:
  - A to r0 is accepted and consumed, and `wr_en` stays 0.
  - B to r0 is accepted (`b_ready` rules apply) but is not pushed.
- `pending[i]` = `fifo_hit[i] | (wr_en && wr_num == i)`. `pending[0]` is always 0.
- FIFO is circular with wrapping read/write pointers. `b_count` is tracked explicitly.
- Reset state:
  - `wr_en=0`, `wr_num=0`, `wr_data=0`.
  - FIFO empty, `b_count=0`, `pending=0`.
  - Consequently `a_ready=1` and `b_ready=1`.
- Reset asserted mid-operation discards all FIFO contents and any staged write immediately (asynchronous). No partial write reaches the regfile after `rst_n` falls.

## Timing
- A latency: accepted at posedge N → `wr_*` valid during cycle N+1 → regfile written at the negedge inside cycle N+1 → readable from posedge N+2.
- B minimum latency: pushed at posedge N → head eligible in cycle N+1 → `wr_*` valid in cycle N+2 if not preempted by A.
- At full, the head is popped and A is blocked for exactly that cycle. The next cycle has `b_count = DEPTH-1`, so A proceeds. Under saturation A and B therefore alternate, with no starvation of either.
- `wr_en` is held for one cycle per write. There are no back-to-back duplicates.
- `pending` updates on the same posedge as the FIFO and output stage. A decode read in cycle N sees the mask for cycle N.

## Test plan
- Reset, then A writes r5=0x1234 at edge 1 → `wr_en=1`, `wr_num=5`, `wr_data=0x1234` in cycle 2; `pending[5]=1` in cycle 2 only.
- B pushes r7=0xAAAA while A idle → `b_count=1` next cycle; write appears one cycle later; `b_count` returns to 0 when `wr_en` is asserted.
- B fills FIFO (DEPTH=2) while A is continuously valid with distinct registers → `a_ready=0` only in the full cycles; writes alternate B, A, B, A; no request lost.
- B queues r9, then A requests r9 → `a_ready=0` until the B r9 write leaves the FIFO; regfile ends holding A's value.
- A writes r0 and B pushes r0 → `wr_en` never asserted, `b_count` unchanged, `pending=0`.
- Drop `rst_n` with 2 FIFO entries and `wr_en=1` → all outputs at reset values immediately; no write after release until a new request arrives.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single regfile write port between the in-order pipeline
//   writeback (A) and the multi-cycle unit path (B). B results are queued
//   in a small circular FIFO. The winning write is registered into wr_*
//   one cycle ahead of the regfile's negedge write. A pending-write mask is
//   exported for decode-stage hazard detection.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_valid/a_ready/a_num/a_data  pipeline writeback request
//   b_valid/b_ready/b_num/b_data  multi-cycle result request (FIFO push)
//   wr_en/wr_num/wr_data        registered regfile write port
//   pending                     bit i set while a write to ri is queued or staged
//   b_count                     current FIFO occupancy
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [4:0]               a_num,
    input  logic [DATA_W-1:0]        a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_num,
    input  logic [DATA_W-1:0]        b_data,
    output logic                     wr_en,
    output logic [4:0]               wr_num,
    output logic [DATA_W-1:0]        wr_data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   b_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]        fifo_num  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    logic        full;
    logic        empty;
    logic        a_fire;
    logic        push;
    logic        pop;
    logic [31:0] fifo_hit;

    assign full  = (b_count == CW'(DEPTH));
    assign empty = (b_count == '0);

    // A slot is occupied when its distance from the read pointer (mod DEPTH)
    // is below the occupancy count.
    always_comb begin
        logic [PW-1:0] offs;
        offs     = '0;
        fifo_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ({1'b0, offs} < b_count) begin
                fifo_hit[fifo_num[i]] = 1'b1;
            end
        end
    end

    // A may not overtake an older queued write to the same register.
    assign a_ready = !full && !((a_num != 5'd0) && fifo_hit[a_num]);
    assign b_ready = !full;
    assign a_fire  = a_valid && a_ready;

    // At full the head always wins (A is blocked then), otherwise A has
    // priority and the head only drains in cycles A does not handshake.
    assign pop  = full || (!a_fire && !empty);
    assign push = b_valid && b_ready && (b_num != 5'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_num[wr_ptr]  <= b_num;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            b_count <= '0;
            wr_en   <= 1'b0;
            wr_num  <= '0;
            wr_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   b_count <= b_count + CW'(1);
                2'b01:   b_count <= b_count - CW'(1);
                default: b_count <= b_count;
            endcase

            if (pop) begin
                wr_en   <= 1'b1;
                wr_num  <= fifo_num[rd_ptr];
                wr_data <= fifo_data[rd_ptr];
            end else if (a_fire && (a_num != 5'd0)) begin
                wr_en   <= 1'b1;
                wr_num  <= a_num;
                wr_data <= a_data;
            end else begin
                wr_en   <= 1'b0;
            end
        end
    end

    always_comb begin
        pending = fifo_hit;
        if (wr_en) pending[wr_num] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_num;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_num;
    logic [31:0] b_data;
    logic        wr_en;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic [31:0] pending;
    logic [1:0]  b_count;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_num   (a_num),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_num   (b_num),
        .b_data  (b_data),
        .wr_en   (wr_en),
        .wr_num  (wr_num),
        .wr_data (wr_data),
        .pending (pending),
        .b_count (b_count)
    );

    typedef struct packed {
        logic [4:0]  num;
        logic [31:0] data;
    } wr_t;

    wr_t         mq[$];      // reference B queue
    wr_t         exp_q[$];   // scoreboard of expected regfile writes
    logic        st_en;
    logic [4:0]  st_num;
    logic [31:0] rf_model [32];
    logic [31:0] dut_rf   [32];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: regfile captures at negedge; every presented write is popped
    // from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            wr_t e;
            dut_rf[wr_num] = wr_data;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_write: got write r%0d=0x%0h expected none", wr_num, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_num", 32'(wr_num), 32'(e.num));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    // One cycle: drive inputs, compare handshake/status outputs against the
    // reference, then advance the reference and queue any expected write.
    task automatic step(input logic av, input logic [4:0] an, input logic [31:0] ad,
                        input logic bv, input logic [4:0] bn, input logic [31:0] bd,
                        output logic a_acc, output logic b_acc);
        logic        m_full, hit, m_ar, a_f, b_f, n_en;
        logic [31:0] m_pend;
        wr_t         n, nb;
        @(posedge clk);
        #1;
        a_valid = av; a_num = an; a_data = ad;
        b_valid = bv; b_num = bn; b_data = bd;
        #1;
        m_full = (mq.size() == DEPTH);
        hit    = 1'b0;
        m_pend = '0;
        foreach (mq[k]) begin
            if (mq[k].num == an) hit = 1'b1;
            m_pend[mq[k].num] = 1'b1;
        end
        if (st_en) m_pend[st_num] = 1'b1;
        m_pend[0] = 1'b0;
        m_ar = !m_full && !(an != 5'd0 && hit);
        check("a_ready", 32'(a_ready), 32'(m_ar));
        check("b_ready", 32'(b_ready), 32'(!m_full));
        check("b_count", 32'(b_count), 32'(mq.size()));
        check("pending", pending, m_pend);
        a_f  = av && m_ar;
        b_f  = bv && !m_full;
        n_en = 1'b0;
        n    = '0;
        if (m_full || (!a_f && mq.size() > 0)) begin
            n    = mq.pop_front();
            n_en = 1'b1;
        end else if (a_f && an != 5'd0) begin
            n.num  = an;
            n.data = ad;
            n_en   = 1'b1;
        end
        if (b_f && bn != 5'd0) begin
            nb.num  = bn;
            nb.data = bd;
            mq.push_back(nb);
        end
        if (n_en) begin
            exp_q.push_back(n);
            rf_model[n.num] = n.data;
        end
        st_en  = n_en;
        st_num = n.num;
        a_acc  = a_f;
        b_acc  = b_f;
    endtask

    task automatic idle(input int n);
        logic aa, ba;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, ba);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   32'(wr_en),   32'd0);
        check({tag, "_wr_num"},  32'(wr_num),  32'd0);
        check({tag, "_wr_data"}, wr_data,      32'd0);
        check({tag, "_b_count"}, 32'(b_count), 32'd0);
        check({tag, "_pending"}, pending,      32'd0);
        check({tag, "_a_ready"}, 32'(a_ready), 32'd1);
        check({tag, "_b_ready"}, 32'(b_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic aa, ba, acc_done;
        int   ai, bi;
        rst_n = 1'b0;
        a_valid = 1'b0; a_num = '0; a_data = '0;
        b_valid = 1'b0; b_num = '0; b_data = '0;
        st_en = 1'b0; st_num = '0;
        for (int r = 0; r < 32; r++) begin
            rf_model[r] = '0;
            dut_rf[r]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // A write r5
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, aa, ba);
        idle(2);

        // B write r7
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA, aa, ba);
        idle(3);

        // Saturation: A continuously valid, B fills the FIFO
        ai = 0; bi = 0;
        for (int c = 0; c < 12; c++) begin
            step(ai < 6, 5'(16 + ai), 32'hA000 + 32'(ai),
                 bi < 6, 5'(24 + bi), 32'hB000 + 32'(bi), aa, ba);
            if (aa) ai++;
            if (ba) bi++;
        end
        idle(4);
        check("sat_all_a_taken", 32'(ai), 32'd6);
        check("sat_all_b_taken", 32'(bi), 32'd6);

        // WAW: B queues r9, A must wait for it
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9009, aa, ba);
        acc_done = 1'b0;
        for (int c = 0; c < 8 && !acc_done; c++) begin
            step(1'b1, 5'd9, 32'hA9A9, 1'b0, 5'd0, 32'd0, aa, ba);
            acc_done = aa;
        end
        check("waw_a_accepted", 32'(acc_done), 32'd1);
        idle(2);
        check("waw_r9_final", dut_rf[9], 32'hA9A9);

        // r0 from both sources
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, aa, ba);
        idle(2);

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 9)), $urandom,
                 $urandom_range(0, 99) < 50, 5'($urandom_range(0, 9)), $urandom, aa, ba);
        end
        idle(2 * DEPTH + 2);
        for (int r = 0; r < 32; r++) check($sformatf("rf_r%0d", r), dut_rf[r], rf_model[r]);
        check("drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two queued entries and a staged write
        step(1'b1, 5'd12, 32'hC12, 1'b1, 5'd10, 32'hB10, aa, ba);
        step(1'b1, 5'd13, 32'hC13, 1'b1, 5'd11, 32'hB11, aa, ba);
        @(posedge clk);
        #2;
        check("pre_reset_count", 32'(b_count), 32'd2);
        check("pre_reset_wr_en", 32'(wr_en), 32'd1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mq.delete();
        exp_q.delete();
        st_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
